// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, framing constants and
// the baud divisor helper used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int unsigned UART_OVERSAMPLE  = 16;
    localparam int unsigned UART_SAMPLE_TICK = 7;
    localparam int unsigned UART_DATA_BITS   = 8;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned uart_divisor(input int unsigned from,
                                                 input int unsigned baud);
        int unsigned per_tick;
        per_tick = baud * UART_OVERSAMPLE;
        return (from + per_tick / 2) / per_tick;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery handshake and status flags between the UART receiver and
// its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_error;
    logic                      overrun;
    logic                      busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_error,
        output overrun,
        output busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_error,
        input  overrun,
        input  busy,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..Divisor-1 and pulses tick on wrap.
// clear holds the count at zero so the tick phase can be realigned.
module uart_baud_tick #(
    parameter int unsigned Divisor = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic ckena,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (Divisor > 1) ? $clog2(Divisor) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Divisor - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
            tick  = ckena;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (ckena) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled with a mid-bit sample point.
// Delivers bytes through a one-entry holding register with valid/ready.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned From = 50000000,
    parameter int unsigned Baud = 115200
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ckena,
    input  logic         rx,
    uart_rx_if.master    rxif
);

    localparam int unsigned Oversample = UART_OVERSAMPLE;
    localparam int unsigned Divisor    = uart_divisor(From, Baud);
    localparam int unsigned BitCntW    = $clog2(UART_DATA_BITS);

    localparam logic [3:0]         TickSample = 4'(UART_SAMPLE_TICK);
    localparam logic [3:0]         TickLast   = 4'(Oversample - 1);
    localparam logic [BitCntW-1:0] BitLast    = BitCntW'(UART_DATA_BITS - 1);

    logic rx_s1_q;
    logic rx_s2_q;
    logic rxs;

    uart_rx_state_t state_q;
    uart_rx_state_t state_d;

    logic [3:0]                tick_cnt_q;
    logic [3:0]                tick_cnt_d;
    logic [BitCntW-1:0]        bit_cnt_q;
    logic [BitCntW-1:0]        bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic [UART_DATA_BITS-1:0] rx_data_q;
    logic [UART_DATA_BITS-1:0] rx_data_d;
    logic                      rx_valid_q;
    logic                      rx_valid_d;
    logic                      frame_error_q;
    logic                      frame_error_d;
    logic                      overrun_q;
    logic                      overrun_d;

    logic tick;
    logic tick_clear;
    logic commit;

    assign rxs        = rx_s2_q;
    assign tick_clear = (state_q == IDLE);

    uart_baud_tick #(
        .Divisor (Divisor)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .ckena (ckena),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        commit        = 1'b0;

        if (rx_valid_q && rxif.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == TickSample) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxs ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs, shift_q[UART_DATA_BITS-1:1]};
                        if (bit_cnt_q == BitLast) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        if (rxs) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A commit overrides the drain above, so a simultaneous drain+commit keeps valid high.
        if (commit) begin
            if (!rx_valid_q || rxif.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (ckena) begin
            rx_s1_q       <= rx;
            rx_s2_q       <= rx_s1_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rxif.rx_data     = rx_data_q;
    assign rxif.rx_valid    = rx_valid_q;
    assign rxif.frame_error = frame_error_q;
    assign rxif.overrun     = overrun_q;
    assign rxif.busy        = (state_q != IDLE);

    a_data_stable: assert property (@(posedge clock) disable iff (reset)
        (rx_valid_q && !rxif.rx_ready && ckena) |=> (rx_valid_q && $stable(rx_data_q)));

    a_flags_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(frame_error_q && overrun_q));

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud (432 clocks per bit).
module tb_uart_rx;

    localparam int BIT = 432;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ckena = 1'b1;
    logic rx    = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .From (50000000),
        .Baud (115200)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ckena (ckena),
        .rx    (rx),
        .rxif  (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observation side: accepted bytes, pulse counts and edge times.
    logic [7:0] got_q [$];
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   valid_rise = 0;
    int   busy_rise = 0;
    int   busy_fall = 0;
    logic valid_prev = 1'b0;
    logic busy_prev = 1'b0;

    always @(negedge clock) begin
        if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
        if (bus.frame_error) fe_cnt++;
        if (bus.overrun) ov_cnt++;
        if (bus.rx_valid && !valid_prev) valid_rise = cyc;
        if (bus.busy && !busy_prev) busy_rise = cyc;
        if (!bus.busy && busy_prev) busy_fall = cyc;
        valid_prev = bus.rx_valid;
        busy_prev  = bus.busy;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    int t_start;

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clock); #1;
        t_start = cyc;
        rx = 1'b0;
        repeat (BIT) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clock);
            #1;
        end
        rx = stop;
        repeat (BIT) @(posedge clock);
        #1;
    endtask

    logic [7:0] t5_exp [4] = '{8'h3C, 8'hC3, 8'hFF, 8'h00};

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        int fe0;
        int ov0;

        bus.rx_ready = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("rst_rx_data", bus.rx_data, 32'h00);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_error", bus.frame_error, 0);
        check("rst_overrun", bus.overrun, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);

        // 0x55 with rx_ready held high
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_byte(8'h55, 1'b1);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("t1_count", got_q.size() - base, 1);
        check("t1_data", got_q[got_q.size() - 1], 32'h55);
        check("t1_latency", valid_rise - t_start, 4107);
        check("t1_fe", fe_cnt - fe0, 0);
        check("t1_ov", ov_cnt - ov0, 0);

        // 100-clock glitch
        base = got_q.size(); fe0 = fe_cnt;
        @(posedge clock); #1;
        t_start = cyc;
        rx = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        rx = 1'b1;
        repeat (400) @(posedge clock);
        @(negedge clock);
        check("t2_busy_rise", busy_rise - t_start, 3);
        check("t2_busy_fall", busy_fall - t_start, 219);
        check("t2_busy_now", bus.busy, 0);
        check("t2_count", got_q.size() - base, 0);
        check("t2_fe", fe_cnt - fe0, 0);

        // 0xA5 with low stop bit, line held low (break)
        base = got_q.size(); fe0 = fe_cnt;
        send_byte(8'hA5, 1'b0);
        repeat (2 * BIT) @(posedge clock);
        @(negedge clock);
        check("t3_busy_in_break", bus.busy, 1);
        check("t3_fe_once", fe_cnt - fe0, 1);
        check("t3_valid", bus.rx_valid, 0);
        @(posedge clock); #1;
        rx = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("t3_busy_after", bus.busy, 0);
        check("t3_fe_total", fe_cnt - fe0, 1);
        check("t3_count", got_q.size() - base, 0);

        // Overrun: 0x12 then 0x34 with rx_ready low
        base = got_q.size(); ov0 = ov_cnt;
        bus.rx_ready = 1'b0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        @(negedge clock);
        check("t4_valid", bus.rx_valid, 1);
        check("t4_data_held", bus.rx_data, 32'h12);
        check("t4_ov", ov_cnt - ov0, 1);
        check("t4_none_taken", got_q.size() - base, 0);
        @(posedge clock); #1;
        bus.rx_ready = 1'b1;
        @(posedge clock); #1;
        bus.rx_ready = 1'b0;
        @(negedge clock);
        check("t4_valid_drained", bus.rx_valid, 0);
        check("t4_taken", got_q.size() - base, 1);
        check("t4_taken_data", got_q[got_q.size() - 1], 32'h12);

        // Reset during data bit 4 of 0xF0, then 0x81
        bus.rx_ready = 1'b1;
        fe0 = fe_cnt;
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (2350) @(posedge clock);
                @(negedge clock);
                check("t6_busy_mid", bus.busy, 1);
                @(posedge clock); #1;
                reset = 1'b1;
                @(negedge clock);
                check("t6_rst_data", bus.rx_data, 32'h00);
                check("t6_rst_valid", bus.rx_valid, 0);
                check("t6_rst_busy", bus.busy, 0);
                check("t6_rst_fe", bus.frame_error, 0);
                check("t6_rst_ov", bus.overrun, 0);
                repeat (3) @(posedge clock);
                #1;
                reset = 1'b0;
            end
        join
        base = got_q.size();
        send_byte(8'h81, 1'b1);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("t6_count", got_q.size() - base, 1);
        check("t6_data", got_q[got_q.size() - 1], 32'h81);
        check("t6_fe", fe_cnt - fe0, 0);

        // Four back-to-back bytes, one-cycle rx_ready per byte
        bus.rx_ready = 1'b0;
        base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send_byte(t5_exp[i], 1'b1);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    int w;
                    w = 0;
                    while (!bus.rx_valid && w < 6000) begin
                        @(negedge clock);
                        w++;
                    end
                    check("t5_valid_seen", bus.rx_valid, 1);
                    @(posedge clock); #1;
                    bus.rx_ready = 1'b1;
                    @(posedge clock); #1;
                    bus.rx_ready = 1'b0;
                end
            end
        join
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("t5_count", got_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_data%0d", i), got_q[base + i], t5_exp[i]);
        end
        check("t5_fe", fe_cnt - fe0, 0);
        check("t5_ov", ov_cnt - ov0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
